// File: rtl/xs_arb_pkg.sv
// Shared types and constants for the xorshift32 round-robin arbiter.
// Optional statistics outputs are enabled by defining XS_ARB_STATS_EN.
package xs_arb_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WARM  = 2'd1,
        SERVE = 2'd2
    } xs_arb_state_t;

    localparam int XS_WIDTH     = 32;
    localparam int WARM_CNT_W   = 8;
    localparam int GRANT_CNT_W  = 32;
    localparam int RESEED_CNT_W = 16;

    localparam logic [XS_WIDTH-1:0] XS_DEFAULT_SEED = 32'h1234_5678;

    // One xorshift32 step with the classic 13/17/5 shift triple.
    function automatic logic [XS_WIDTH-1:0] xs_step(input logic [XS_WIDTH-1:0] x);
        logic [XS_WIDTH-1:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

endpackage

// File: rtl/xorshift32.sv
// Free-running xorshift32 generator; advances one step per cycle unless reseeded.
module xorshift32
    import xs_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XS_WIDTH-1:0] seed,
    input  logic                re_seed,
    output logic [XS_WIDTH-1:0] rnd
);

    // A zero state would lock the generator, so reset lands on a nonzero value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rnd <= XS_DEFAULT_SEED;
        end else if (re_seed) begin
            rnd <= seed;
        end else begin
            rnd <= xs_step(rnd);
        end
    end

endmodule

// File: rtl/xorshift32_arb.sv
// Round-robin scheduler sharing one xorshift32 among NUM_REQ consumers.
// Define XS_ARB_STATS_EN to add the grant_total / reseed_total counters.
module xorshift32_arb
    import xs_arb_pkg::*;
#(
    parameter int                  NUM_REQ      = 4,
    parameter int                  WARMUP       = 4,
    parameter logic [XS_WIDTH-1:0] DEFAULT_SEED = XS_DEFAULT_SEED
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [XS_WIDTH-1:0]        rnd_out,
    output logic                       rnd_valid,
    output logic [$clog2(NUM_REQ)-1:0] rnd_id,
    input  logic                       seed_req,
    input  logic [XS_WIDTH-1:0]        seed_in,
    output logic                       seed_ack,
    output logic                       busy
`ifdef XS_ARB_STATS_EN
    ,
    output logic [GRANT_CNT_W-1:0]     grant_total,
    output logic [RESEED_CNT_W-1:0]    reseed_total
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    xs_arb_state_t         state;
    logic [WARM_CNT_W-1:0] warm_cnt;
    logic [XS_WIDTH-1:0]   seed_q;
    logic [XS_WIDTH-1:0]   rnd;
    logic [ID_W-1:0]       last;
    logic [ID_W-1:0]       rr_idx;
    logic [ID_W-1:0]       pick_p0;
    logic                  pick_vld_p0;
    logic                  serve_ok;
    logic                  accept;
    logic                  grant_p0;

    xorshift32 u_gen (
        .clk     (clk),
        .rst_n   (~rst),
        .seed    (seed_q),
        .re_seed (state == LOAD),
        .rnd     (rnd)
    );

    // Stage p0: round-robin pick, scanning from the farthest offset down so
    // the nearest requester after last wins.
    always_comb begin
        rr_idx      = '0;
        pick_p0     = last;
        pick_vld_p0 = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            rr_idx = ID_W'((int'(last) + i) % NUM_REQ);
            if (req[rr_idx]) begin
                pick_p0     = rr_idx;
                pick_vld_p0 = 1'b1;
            end
        end
    end

    assign serve_ok = (state == SERVE) && !rst;
    assign accept   = serve_ok && seed_req;
    assign grant_p0 = serve_ok && !seed_req && pick_vld_p0;
    assign seed_ack = accept;
    assign busy     = rst || (state != SERVE);

    always_comb begin
        gnt = '0;
        if (grant_p0) begin
            gnt[pick_p0] = 1'b1;
        end
    end

    // Stage p1: registered grant data plus lifecycle control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            warm_cnt  <= '0;
            seed_q    <= DEFAULT_SEED;
            last      <= ID_W'(NUM_REQ - 1);
            rnd_out   <= '0;
            rnd_id    <= '0;
            rnd_valid <= 1'b0;
        end else begin
            rnd_valid <= grant_p0;
            if (grant_p0) begin
                rnd_out <= rnd;
                rnd_id  <= pick_p0;
                last    <= pick_p0;
            end
            case (state)
                LOAD: begin
                    warm_cnt <= WARM_CNT_W'(WARMUP);
                    state    <= WARM;
                end
                WARM: begin
                    if (warm_cnt <= WARM_CNT_W'(1)) begin
                        state <= SERVE;
                    end else begin
                        warm_cnt <= warm_cnt - 1'b1;
                    end
                end
                SERVE: begin
                    if (accept) begin
                        seed_q <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
                        state  <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef XS_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_total  <= '0;
            reseed_total <= '0;
        end else begin
            if (grant_p0) begin
                grant_total <= grant_total + 1'b1;
            end
            if (accept && (reseed_total != '1)) begin
                reseed_total <= reseed_total + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xorshift32_arb.sv
// Self-checking bench for xorshift32_arb: directed scenarios plus a randomized
// run against a cycle-level behavioural model.
module tb_xorshift32_arb;

    localparam int          N  = 4;
    localparam int          WU = 1;
    localparam logic [31:0] DS = 32'h1;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [31:0] rnd_out;
    logic        rnd_valid;
    logic [1:0]  rnd_id;
    logic        seed_req;
    logic [31:0] seed_in;
    logic        seed_ack;
    logic        busy;
`ifdef XS_ARB_STATS_EN
    logic [31:0] grant_total;
    logic [15:0] reseed_total;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state: one seed epoch = busy LOAD/WARM cycles then SERVE
    // cycles numbered m_j, where SERVE cycle j samples xs^(WARMUP+j)(seed).
    int          m_busy_left;
    int          m_j;
    logic [31:0] m_seed;
    int          m_last;
    int          m_grants;
    int          m_reseeds;
    logic        ex_valid;
    logic [31:0] ex_out;
    logic [1:0]  ex_id;

    always #5 clk = ~clk;

    xorshift32_arb #(
        .NUM_REQ      (N),
        .WARMUP       (WU),
        .DEFAULT_SEED (DS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .rnd_out      (rnd_out),
        .rnd_valid    (rnd_valid),
        .rnd_id       (rnd_id),
        .seed_req     (seed_req),
        .seed_in      (seed_in),
        .seed_ack     (seed_ack),
        .busy         (busy)
`ifdef XS_ARB_STATS_EN
        ,
        .grant_total  (grant_total),
        .reseed_total (reseed_total)
`endif
    );

    function automatic logic [31:0] xs(input logic [31:0] x);
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [31:0] xs_n(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) s = xs(s);
        return s;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; seed_req = 1'b0; seed_in = '0;
        tick();
        tick();
        rst = 1'b0;
        m_busy_left = 1 + WU; m_j = 0; m_seed = DS; m_last = N - 1;
        m_grants = 0; m_reseeds = 0; ex_valid = 1'b0; ex_out = '0; ex_id = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; seed_req = 1'b1; seed_in = 32'h5;
        tick();
        tick();
        checks++;
        if (gnt !== '0 || seed_ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb gnt=%b ack=%b busy=%b required 0000/0/1", gnt, seed_ack, busy);
        end
        checks++;
        if (rnd_valid !== 1'b0 || rnd_out !== 32'h0 || rnd_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs valid=%b out=%h id=%0d required 0/0/0", rnd_valid, rnd_out, rnd_id);
        end
`ifdef XS_ARB_STATS_EN
        checks++;
        if (grant_total !== 32'h0 || reseed_total !== 16'h0) begin
            errors++;
            $display("FAIL reset_stats grants=%0d reseeds=%0d required 0/0", grant_total, reseed_total);
        end
`endif
        rst = 1'b0; req = '0; seed_req = 1'b0;
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req = 4'b0001;
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        checks++;
        if (n != 2) begin errors++; $display("FAIL single_busy cycles=%0d required 2", n); end
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt gnt=%b required 0001", gnt); end
        tick();
        checks++;
        if (rnd_valid !== 1'b1 || rnd_out !== 32'd270369 || rnd_id !== 2'd0) begin
            errors++;
            $display("FAIL single_v0 valid=%b out=%0d id=%0d required 1/270369/0", rnd_valid, rnd_out, rnd_id);
        end
        tick();
        checks++;
        if (rnd_valid !== 1'b1 || rnd_out !== 32'd67634689 || rnd_id !== 2'd0) begin
            errors++;
            $display("FAIL single_v1 valid=%b out=%0d id=%0d required 1/67634689/0", rnd_valid, rnd_out, rnd_id);
        end
    endtask

    task automatic test_all();
        int n;
        logic [3:0] eg;
        do_reset();
        req = 4'b1111;
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        for (int k = 0; k < 6; k++) begin
            eg = 4'b0001 << (k % 4);
            if (k < 5) begin
                checks++;
                if (gnt !== eg) begin errors++; $display("FAIL all_gnt k=%0d gnt=%b required %b", k, gnt, eg); end
            end
            if (k > 0) begin
                checks++;
                if (rnd_valid !== 1'b1 || rnd_id !== 2'((k - 1) % 4) || rnd_out !== xs_n(DS, WU + k - 1)) begin
                    errors++;
                    $display("FAIL all_data k=%0d valid=%b id=%0d out=%h required 1/%0d/%h",
                             k, rnd_valid, rnd_id, rnd_out, (k - 1) % 4, xs_n(DS, WU + k - 1));
                end
            end
            tick();
        end
    endtask

    task automatic test_sparse();
        int n;
        int exp_ids[3] = '{3, 1, 3};
        do_reset();
        req = 4'b0010;
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL sparse_pre gnt=%b required 0010", gnt); end
        tick();
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== (4'b0001 << exp_ids[k]) || (gnt & ~req) !== 4'b0000) begin
                errors++;
                $display("FAIL sparse_gnt k=%0d gnt=%b required index %0d", k, gnt, exp_ids[k]);
            end
            tick();
        end
    endtask

    task automatic test_reseed_zero();
        int n;
        do_reset();
        req = 4'b0001;
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        tick();
        seed_req = 1'b1; seed_in = 32'h0;
        #1;
        checks++;
        if (seed_ack !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rz_accept ack=%b gnt=%b busy=%b required 1/0000/0", seed_ack, gnt, busy);
        end
        tick();
        seed_req = 1'b0;
        checks++;
        if (seed_ack !== 1'b0 || rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rz_after ack=%b valid=%b required 0/0", seed_ack, rnd_valid);
        end
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        checks++;
        if (n != 2) begin errors++; $display("FAIL rz_busy cycles=%0d required 2", n); end
        tick();
        checks++;
        if (rnd_valid !== 1'b1 || rnd_out !== 32'd270369) begin
            errors++;
            $display("FAIL rz_value valid=%b out=%0d required 1/270369", rnd_valid, rnd_out);
        end
    endtask

    task automatic test_reseed_warm();
        int n;
        logic [31:0] s;
        s = 32'hDEAD_BEEF;
        do_reset();
        req = 4'b0001;
        tick();
        seed_req = 1'b1; seed_in = s;
        #1;
        checks++;
        if (seed_ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rw_warm ack=%b busy=%b required 0/1", seed_ack, busy);
        end
        tick();
        checks++;
        if (seed_ack !== 1'b1 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rw_serve ack=%b gnt=%b required 1/0000", seed_ack, gnt);
        end
        tick();
        seed_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        tick();
        checks++;
        if (n != 2 || rnd_valid !== 1'b1 || rnd_out !== xs_n(s, WU) || rnd_id !== 2'd0) begin
            errors++;
            $display("FAIL rw_value busy=%0d valid=%b out=%h id=%0d required 2/1/%h/0",
                     n, rnd_valid, rnd_out, rnd_id, xs_n(s, WU));
        end
    endtask

    task automatic test_rst_mid();
        int n;
        do_reset();
        req = 4'b1111;
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (rnd_valid !== 1'b1) begin errors++; $display("FAIL rst_inflight valid=%b required 1", rnd_valid); end
        tick();
        rst = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1 || rnd_valid !== 1'b0 || rnd_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_after gnt=%b busy=%b valid=%b out=%h required 0000/1/0/0", gnt, busy, rnd_valid, rnd_out);
        end
`ifdef XS_ARB_STATS_EN
        checks++;
        if (grant_total !== 32'h0) begin errors++; $display("FAIL rst_stats grants=%0d required 0", grant_total); end
`endif
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; tick(); end
        tick();
        checks++;
        if (n != 2 || rnd_valid !== 1'b1 || rnd_out !== 32'd270369 || rnd_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_value busy=%0d valid=%b out=%0d id=%0d required 2/1/270369/0", n, rnd_valid, rnd_out, rnd_id);
        end
    endtask

    task automatic test_random();
        logic [3:0] e_gnt;
        logic       e_ack, e_busy, prev_ack;
        int         p;
        do_reset();
        prev_ack = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            if (seed_req && prev_ack) begin
                seed_req = 1'b0;
            end else if (!seed_req && $urandom_range(0, 19) == 0) begin
                seed_req = 1'b1;
                seed_in  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            end
            #1;
            e_gnt = '0; e_ack = 1'b0; e_busy = 1'b1; p = -1;
            if (!rst && m_busy_left == 0) begin
                e_busy = 1'b0;
                if (seed_req) e_ack = 1'b1;
                else if (req != '0) begin
                    p = rr_pick(m_last, req);
                    e_gnt = 4'b0001 << p;
                end
            end
            checks++;
            if (gnt !== e_gnt || seed_ack !== e_ack || busy !== e_busy) begin
                errors++;
                $display("FAIL rand_comb cyc=%0d gnt=%b ack=%b busy=%b required %b/%b/%b",
                         cyc, gnt, seed_ack, busy, e_gnt, e_ack, e_busy);
            end
            checks++;
            if (rnd_valid !== ex_valid || (ex_valid && (rnd_out !== ex_out || rnd_id !== ex_id))) begin
                errors++;
                $display("FAIL rand_data cyc=%0d valid=%b out=%h id=%0d required %b/%h/%0d",
                         cyc, rnd_valid, rnd_out, rnd_id, ex_valid, ex_out, ex_id);
            end
`ifdef XS_ARB_STATS_EN
            checks++;
            if (grant_total !== 32'(m_grants) || reseed_total !== 16'(m_reseeds)) begin
                errors++;
                $display("FAIL rand_stats cyc=%0d grants=%0d reseeds=%0d required %0d/%0d",
                         cyc, grant_total, reseed_total, m_grants, m_reseeds);
            end
`endif
            ex_valid = 1'b0;
            if (rst) begin
                m_busy_left = 1 + WU; m_j = 0; m_seed = DS; m_last = N - 1;
                m_grants = 0; m_reseeds = 0;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end else if (seed_req) begin
                m_seed = (seed_in == 32'h0) ? DS : seed_in;
                m_busy_left = 1 + WU; m_j = 0;
                if (m_reseeds < 16'hFFFF) m_reseeds++;
            end else begin
                if (p >= 0) begin
                    ex_valid = 1'b1; ex_out = xs_n(m_seed, WU + m_j); ex_id = 2'(p);
                    m_last = p; m_grants++;
                end
                m_j++;
            end
            prev_ack = e_ack;
            tick();
        end
        rst = 1'b0; seed_req = 1'b0; req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; seed_req = 1'b0; seed_in = '0;
        test_reset();
        test_single();
        test_all();
        test_sparse();
        test_reseed_zero();
        test_reseed_warm();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xorshift32_arb.md
# xorshift32_arb

Round-robin scheduler that shares one `xorshift32` generator among `NUM_REQ` consumers. It sequences the generator's lifecycle: post-reset seeding, warm-up discard, serving requests, and run-time reseeding. Each accepted request receives one 32-bit value tagged with the requester index. The block sits between the stochastic-compute lanes and the single generator instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WARMUP`, 4: generator outputs discarded after every seed load, 1..255.
- `DEFAULT_SEED`, 32'h1234_5678: seed used after reset and as a substitute for a zero seed; must be nonzero.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `gnt`  out  NUM_REQ  one-hot grant, combinational, valid only in SERVE.
- `rnd_out`  out  32  granted value, registered.
- `rnd_valid`  out  1  `rnd_out`/`rnd_id` valid, one-cycle pulse per grant.
- `rnd_id`  out  $clog2(NUM_REQ)  index of the requester that owns `rnd_out`.
- `seed_req`  in  1  reseed request, held until `seed_ack`.
- `seed_in`  in  32  reseed value, stable while `seed_req` is high.
- `seed_ack`  out  1  one-cycle pulse when the reseed is accepted.
- `busy`  out  1  high in every state other than SERVE.

## Operation
- FSM states: LOAD, WARM, SERVE. Reset enters LOAD.
- LOAD (1 cycle): drive the generator with `re_seed=1` and the latched seed, load warm counter = `WARMUP`, then go to WARM.
- WARM: decrement the counter each cycle. When the count reaches 1, go to SERVE. No grants are issued in this state.
- SERVE: on each cycle with `seed_req=0` and any `req` bit set, assert exactly one `gnt` bit.
  - Priority starts at `last+1` mod `NUM_REQ`. On a grant, `last` is updated to the granted index.
  - After reset, `last = NUM_REQ-1`, so requester 0 has highest priority.
- Handshake: a grant is a `req&gnt` cycle. A requester holding `req` high receives one value per grant. With only one requester active, it is granted every cycle.
- Data: the generator's current `rnd` in the grant cycle is registered into `rnd_out`, and the index into `rnd_id`. The generator free-runs one step per cycle, so consecutive grants yield consecutive xorshift outputs.
- Reseed: when `seed_req` is high in SERVE:
  - Pulse `seed_ack` in that cycle and latch `seed_in`. A zero `seed_in` is replaced by `DEFAULT_SEED`.
  - Go to LOAD. No grant is issued that cycle, because reseed wins over `req`.
- `seed_req` in LOAD/WARM is ignored (no ack); the requester keeps holding it.
- Reset values: `gnt=0`, `rnd_out=0`, `rnd_valid=0`, `rnd_id=0`, `seed_ack=0`, `busy=1`. The latched seed resets to `DEFAULT_SEED`.
- `rst` in any state returns to LOAD on the next cycle. An in-flight `rnd_valid` still emits for a grant made before reset only if that grant was in the previous cycle; otherwise outputs are reset.

## Timing
- LOAD in cycle t puts `rnd = seed` at t+1. WARM occupies t+1..t+WARMUP. The first SERVE cycle is t+WARMUP+1 and samples xs^WARMUP(seed).
- Grant-to-data latency is 1 cycle: a grant in cycle c gives `rnd_valid`, `rnd_out`, `rnd_id` in c+1.
- Throughput is one value per cycle across all requesters.
- Reseed cost: 1 (accept) + 1 (LOAD) + WARMUP cycles with no grants.

## Configuration
- `XS_ARB_STATS_EN` defined: adds two outputs.
  - `grant_total` [31:0]: count of grants, wraps at 2^32.
  - `reseed_total` [15:0]: accepted reseeds, excluding the post-reset load; saturates at 16'hFFFF.
  - Both counters reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package `xs_arb_pkg`:
  - state enum typedef `xs_arb_state_t` (LOAD/WARM/SERVE);
  - `XS_WIDTH = 32`;
  - default-seed constant;
  - stats counter widths.
- One sub-module: the existing `xorshift32` (ports `clk`, `rst_n`, `seed`, `re_seed`, `rnd`), with `rst_n` driven by `~rst`. The round-robin pick stays inline.

## Test plan
- Parameters `NUM_REQ=4`, `WARMUP=1`, `DEFAULT_SEED=32'h1`. Reset, then hold `req=4'b0001` → `busy` is high for 2 cycles, then consecutive `rnd_valid` pulses with `rnd_out` = 270369, then 67634689, `rnd_id=0`.
- Same parameters, `req=4'b1111` held → `gnt` sequence 0,1,2,3,0. Values follow the same sequence as above, in order, with matching `rnd_id`.
- `req=4'b1010`, with requester 1 granted last → next grant goes to 3, then 1, then 3. No grant to an idle index.
- `seed_req` with `seed_in=0` in the same cycle as `req=4'b0001` → `seed_ack` pulses, no `gnt` that cycle, `busy` high for 2 cycles, first value after is 270369.
- `seed_req` asserted during WARM → no ack until the first SERVE cycle, which acks and issues no grant.
- `rst` asserted mid-SERVE with `req` held → `gnt=0` and `busy=1` the next cycle, full LOAD/WARM sequence is repeated, and the first value is 270369 again. With `XS_ARB_STATS_EN`, `grant_total` returns to 0.
